// File: rtl/dds_period_meter.sv
// dds_period_meter
// Measures the average period of the DDS sine output, in clock cycles, over
// 2^AVG_LOG2 periods, together with the min/max sample seen in that window.
// Each measurement is armed by start_i. The result is returned through a
// valid/ready handshake. A counter saturating before the window completes
// produces a timeout result instead of a measurement.

module dds_period_meter #(
    parameter int SMP_W    = 14,
    parameter int CNT_W    = 24,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sin_v,
    input  logic [SMP_W-1:0] sin_o,
    input  logic             res_rdy,
    output logic             res_v,
    output logic [CNT_W-1:0] period_o,
    output logic [SMP_W-1:0] amp_max_o,
    output logic [SMP_W-1:0] amp_min_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // The period counter needs one spare bit so it can reach 2^AVG_LOG2.
    localparam int               PER_W     = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = '1;
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'((1 << AVG_LOG2) - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] per;
    logic [SMP_W-1:0] run_max;
    logic [SMP_W-1:0] run_min;

    logic             cnt_at_limit;
    logic             last_xing;
    logic             go_done;
    logic             go_timeout;
    logic [SMP_W-1:0] nxt_max;
    logic [SMP_W-1:0] nxt_min;
    logic [CNT_W:0]   total;

    // Decode the terminating conditions and the running extrema including this cycle's sample.
    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        cnt_at_limit = (cnt == CNT_LIMIT);
        last_xing    = sin_v && (per == PER_LAST);
        nxt_max      = (sin_o > run_max) ? sin_o : run_max;
        nxt_min      = (sin_o < run_min) ? sin_o : run_min;
        // cnt reads one less than the elapsed cycles on the terminating edge.
        // The extra bit keeps the +1 from wrapping when cnt sits at its limit.
        total        = {1'b0, cnt} + (CNT_W+1)'(1);
        go_done      = (state == S_MEAS) && last_xing;
        // A terminating crossing on the limit edge still completes normally.
        go_timeout   = cnt_at_limit &&
                       (((state == S_SYNC) && !sin_v) ||
                        ((state == S_MEAS) && !last_xing));
    end

    // Control FSM: arm, wait for the first crossing, measure, hold the result.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (sin_v) begin
                        state <= S_MEAS;
                    end else if (go_timeout) begin
                        state <= S_DONE;
                    end
                end
                S_MEAS: begin
                    if (go_done || go_timeout) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start_i is ignored here, including on the handshake edge.
                    if (res_rdy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Measurement datapath: saturating cycle counter, crossing counter, running min/max.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            per     <= '0;
            run_max <= '0;
            run_min <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cnt <= '0;
                    end
                end
                S_SYNC: begin
                    if (sin_v) begin
                        // The window opens after the first crossing. That cycle's sample is excluded.
                        cnt     <= '0;
                        per     <= '0;
                        run_max <= '0;
                        run_min <= '1;
                    end else if (!cnt_at_limit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    if (!cnt_at_limit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    run_max <= nxt_max;
                    run_min <= nxt_min;
                    if (sin_v) begin
                        per <= per + PER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: capture on completion or timeout, hold through and after the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_v     <= 1'b0;
            period_o  <= '0;
            amp_max_o <= '0;
            amp_min_o <= '0;
            timeout_o <= 1'b0;
        end else if (go_done) begin
            res_v     <= 1'b1;
            period_o  <= CNT_W'(total >> AVG_LOG2);
            amp_max_o <= nxt_max;
            amp_min_o <= nxt_min;
            timeout_o <= 1'b0;
        end else if (go_timeout) begin
            res_v     <= 1'b1;
            period_o  <= '1;
            amp_max_o <= '0;
            amp_min_o <= '0;
            timeout_o <= 1'b1;
        end else if ((state == S_DONE) && res_rdy) begin
            res_v <= 1'b0;
        end
    end

    assign busy_o = (state != S_IDLE);

endmodule

// File: doc/dds_period_meter.md
Name: dds_period_meter

Overview:
- Downstream consumer of the DDS sine generator output: takes the 14-bit sine sample stream and its once-per-period zero-crossing strobe.
- On command, measures the average sine period in clock cycles over 2^AVG_LOG2 periods, and the min/max sample amplitude over the same window.
- Returns one result through a valid/ready handshake.
- Used by the bench and by the control loop to close on the programmed frequency word.

Parameters:
- SMP_W, 14, sine sample width.
- CNT_W, 24, cycle counter / period result width; also sets the timeout limit 2^CNT_W-1.
- AVG_LOG2, 2, log2 of number of periods averaged (2 -> 4 periods); range 0..4.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- start_i  in  1  single-cycle arm pulse; honoured only in IDLE.
- sin_v  in  1  zero-crossing strobe from the sine generator (one cycle per period).
- sin_o  in  SMP_W  sine sample, unsigned.
- res_rdy  in  1  result consumer ready.
- res_v  out  1  result valid.
- period_o  out  CNT_W  average period in cycles (truncated).
- amp_max_o  out  SMP_W  largest sin_o in window.
- amp_min_o  out  SMP_W  smallest sin_o in window.
- timeout_o  out  1  result is a timeout, not a measurement.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - Single clock.
  - rst sampled on posedge; rst==0 forces IDLE and clears all internal state, regardless of current state (including mid-measurement and while res_v is high).
  - Reset values: res_v=0, period_o=0, amp_max_o=0, amp_min_o=0, timeout_o=0, busy_o=0.
- States: IDLE, SYNC, MEAS, DONE.
- IDLE:
  - start_i=1 -> SYNC, cnt<=0.
  - sin_v in the same cycle as start_i is ignored.
- SYNC (wait for first crossing):
  - cnt increments each cycle.
  - sin_v=1 -> MEAS, with cnt<=0, per<=0, max<=0, min<=all-ones.
  - cnt==2^CNT_W-1 with no sin_v -> timeout exit.
- MEAS:
  - Every cycle: cnt<=cnt+1; max<=max(max,sin_o); min<=min(min,sin_o).
  - On sin_v: per<=per+1.
  - When sin_v arrives and per==2^AVG_LOG2-1 -> DONE. Same edge captures:
    - period_o<=(cnt+1)>>AVG_LOG2
    - amp_max_o/amp_min_o including that cycle's sin_o
    - timeout_o<=0, res_v<=1
  - Total measured = cycles between first and last crossing.
  - Example: crossings 100 cycles apart, first at t0 -> at t0+100 cnt reads 99, total 100.
  - cnt==2^CNT_W-1 before completion -> timeout exit.
- Timeout exit (from SYNC or MEAS): DONE with period_o=all-ones, amp_max_o=0, amp_min_o=0, timeout_o=1, res_v=1.
- DONE:
  - res_v held high, all result outputs stable until res_v&&res_rdy.
  - On handshake -> IDLE, res_v<=0 next edge.
  - Result outputs retain values after handshake until the next result capture or reset.
  - start_i in DONE, including in the handshake cycle, is ignored.
- Latency:
  - res_v rises the cycle after the edge that samples the terminating sin_v.
  - A new start is accepted no earlier than the cycle after the handshake.
- Width rules:
  - cnt is CNT_W bits and never wraps; saturation is the timeout.
  - Division is a right shift (truncation, no rounding).
  - Min/max comparisons are unsigned.
- Simultaneous events: sin_v on the same edge as the cnt limit in MEAS completes normally if it is the terminating crossing; otherwise timeout wins.
- busy_o is decoded from the state register; no extra latency.

Test Plan:
1. Basic period (defaults): start, sin_v every 100 cycles for 5 crossings, res_rdy=1 -> res_v one cycle after 5th crossing, period_o=100, timeout_o=0, busy_o low the cycle after handshake.
2. Truncation: crossing gaps 100,101,101,101 -> total 403, period_o=100; gaps 103,103,103,103 -> period_o=103.
3. Amplitude: drive sin_o as a triangle 0x0100..0x3E00 during MEAS with sin_v every 64 cycles -> amp_max_o=0x3E00, amp_min_o=0x0100; samples outside the window (IDLE/SYNC) must not affect them.
4. Timeout (CNT_W=8):
   - start, no sin_v -> res_v after 255 SYNC cycles, timeout_o=1, period_o=0xFF, amp_max_o=0, amp_min_o=0.
   - Repeat with one sin_v then silence -> timeout from MEAS.
5. Backpressure: hold res_rdy=0 for 20 cycles after res_v -> res_v and all results stable; start_i pulsed during DONE ignored; res_rdy=1 -> IDLE next cycle, results retained; a fresh start then measures correctly.
6. Reset mid-op: assert rst=0 for 1 cycle in MEAS after 2 crossings -> next cycle IDLE, busy_o=0, res_v=0, all outputs 0; subsequent start with 50-cycle crossings -> period_o=50.
